gcd_run_ctrl: RTL
=================

GCD_RUN_CTRL -- requirements
Module: gcd_run_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 29010, maximum RUN cycles before forced stop.
REQ-002 Parameter DRAIN_CYCLES, default 4, post-run cycles granted to the pipeline to retire stores.
REQ-003 Parameters ADDR_A/ADDR_B/ADDR_R, defaults 16/20/12: byte addresses of Mem[4], Mem[5], Mem[3].
REQ-004 clk  in  1  system clock, rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 sw_a  in  8  operand A switches (i0..i7, i0 = LSB).
REQ-007 sw_b  in  8  operand B switches (i8..i15, i8 = LSB).
REQ-008 start  in  1  run request, level-sampled each cycle.
REQ-009 cpu_halt  in  1  CPU has reached its terminating instruction.
REQ-010 cpu_mem_we / cpu_mem_addr / cpu_mem_wdata  in  1/32/32  CPU MEM-stage data port.
REQ-011 mem_rdata  in  32  data memory combinational read data.
REQ-012 mem_we / mem_addr / mem_wdata  out  1/32/32  arbitrated data memory port.
REQ-013 cpu_rst  out  1  holds CPU in reset; cpu_run  out  1  enables PC/fetch advance.
REQ-014 result  out  32  latched Mem[3]; done  out  1  result valid; timeout  out  1  run hit TIMEOUT_CYCLES.

Function
REQ-015 FSM states SHALL be IDLE, LOAD_A, LOAD_B, RUN, DRAIN, READ, DONE.
REQ-016 IDLE/DONE: start=1 -> LOAD_A; sw_a/sw_b captured that edge; done, timeout cleared; start otherwise ignored.
REQ-017 LOAD_A: mem_we=1, mem_addr=ADDR_A, mem_wdata={24'b0,sw_a captured}; one cycle -> LOAD_B.
REQ-018 LOAD_B: same with ADDR_B and captured sw_b; one cycle -> RUN.
REQ-019 RUN: cpu_rst=0, cpu_run=1, memory port driven by CPU signals unchanged; cycle counter increments from 0.
REQ-020 RUN exit: cpu_halt=1 -> DRAIN; else counter==TIMEOUT_CYCLES-1 -> DRAIN with timeout set; halt wins on same cycle, timeout stays 0.
REQ-021 DRAIN: cpu_rst=0, cpu_run=0, port still CPU-owned for exactly DRAIN_CYCLES cycles -> READ.
REQ-022 READ: mem_we=0, mem_addr=ADDR_R; result<=mem_rdata at end of cycle -> DONE.
REQ-023 DONE: done=1, result held, cpu_rst=1.
REQ-024 Outside RUN/DRAIN the controller owns the port; mem_we=0 except LOAD_A/LOAD_B; cpu_rst=1 except RUN/DRAIN.
REQ-025 Latency start->first RUN cycle SHALL be 3 edges; halt->done SHALL be DRAIN_CYCLES+2 edges.
REQ-026 Counter width SHALL be clog2(TIMEOUT_CYCLES)+1 and never wrap; switch changes after capture SHALL have no effect.

Reset
REQ-027 rst SHALL force IDLE, cpu_rst=1, cpu_run=0, mem_we=0, mem_addr=0, mem_wdata=0, result=0, done=0, timeout=0, counter=0.
REQ-028 rst mid-run (any state) SHALL abort immediately; no memory write SHALL issue during the reset-asserted cycle.

Structure
REQ-029 State encoding and default ADDR_A/ADDR_B/ADDR_R constants SHALL live in the shared cpu package.
REQ-030 One sub-module, run_timer (counter + terminal-count compare), is natural; port mux stays in gcd_run_ctrl.
REQ-031 top SHALL instantiate gcd_run_ctrl between switch inputs, CPU MEM stage and data memory.

Verification
REQ-032 sw_a=12, sw_b=18, start pulse, CPU stub writes 6 to addr 12 then halts -> Mem[4]=12, Mem[5]=18, result=6, done=1, timeout=0.
REQ-033 Stub never halts, TIMEOUT_CYCLES=50 -> DRAIN after 50 RUN cycles, timeout=1, done=1.
REQ-034 cpu_halt asserted on cycle TIMEOUT_CYCLES-1 -> timeout=0.
REQ-035 rst pulsed during RUN -> next edge IDLE, cpu_rst=1, mem_we=0, done=0.
REQ-036 Switches toggled after start; start held high in DONE -> second run uses new captured values, done cleared then reasserted.
REQ-037 Stub store to addr 12 issued 3 cycles after halt -> captured in result (within DRAIN window).

Source files
------------

// File: rtl/gcd_run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gcd_run_ctrl_pkg
// Shared definitions for the GCD run controller:
//   - ctrl_state_t : controller FSM state encoding
//   - DEF_ADDR_*   : default byte addresses of Mem[4] (A), Mem[5] (B),
//                    Mem[3] (result) in the CPU data memory
//   - DEF_*_CYCLES : default run timeout and post-run drain length
//   - zext_byte()  : zero-extends a switch byte to a memory word
// ---------------------------------------------------------------------------
package gcd_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_READ   = 3'd5,
        ST_DONE   = 3'd6
    } ctrl_state_t;

    localparam int unsigned DEF_ADDR_A         = 16;
    localparam int unsigned DEF_ADDR_B         = 20;
    localparam int unsigned DEF_ADDR_R         = 12;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 29010;
    localparam int unsigned DEF_DRAIN_CYCLES   = 4;

    function automatic logic [31:0] zext_byte(input logic [7:0] b);
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/gcd_run_ctrl_run_timer.sv
// ---------------------------------------------------------------------------
// gcd_run_ctrl_run_timer
// Cycle counter with terminal-count compare. Counts from 0 on the first
// enabled cycle, clears whenever disabled, and saturates at LIMIT-1 so it
// can never wrap.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   i_en  in  count enable (counter held at 0 while low)
//   o_tc  out counter currently equals LIMIT-1
// LIMIT must be at least 1.
// ---------------------------------------------------------------------------
module gcd_run_ctrl_run_timer #(
    parameter int unsigned LIMIT = 29010
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CNT_W = $clog2(LIMIT) + 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == TC_VAL);
    assign o_tc = w_tc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!i_en) begin
            r_count <= '0;
        end else if (!w_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/gcd_run_ctrl.sv
// ---------------------------------------------------------------------------
// gcd_run_ctrl
// Run controller that sits between the operand switches, the CPU MEM stage
// and the data memory. On start it writes the captured switch operands into
// Mem[4]/Mem[5], releases the CPU until it halts (or a timeout expires),
// grants a few drain cycles for in-flight stores, then reads Mem[3] into
// result and raises done.
// Ports:
//   clk, rst                         clock / async active-high reset
//   sw_a, sw_b                       operand switches (8 bits each)
//   start                            run request, level-sampled
//   cpu_halt                         CPU reached its terminating instruction
//   cpu_mem_we/addr/wdata            CPU MEM-stage store port
//   mem_rdata                        data memory combinational read data
//   mem_we/addr/wdata                arbitrated data memory port
//   cpu_rst, cpu_run                 CPU reset hold / fetch enable
//   result, done, timeout            latched Mem[3], result valid, timed out
// ---------------------------------------------------------------------------
module gcd_run_ctrl
    import gcd_run_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter logic [31:0] ADDR_A         = 32'(DEF_ADDR_A),
    parameter logic [31:0] ADDR_B         = 32'(DEF_ADDR_B),
    parameter logic [31:0] ADDR_R         = 32'(DEF_ADDR_R)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw_a,
    input  logic [7:0]  sw_b,
    input  logic        start,
    input  logic        cpu_halt,
    input  logic        cpu_mem_we,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        cpu_run,
    output logic [31:0] result,
    output logic        done,
    output logic        timeout
);

    ctrl_state_t r_state;
    ctrl_state_t w_next;

    logic [7:0]  r_sw_a;
    logic [7:0]  r_sw_b;
    logic [31:0] r_result;
    logic        r_done;
    logic        r_timeout;

    logic        w_accept;
    logic        w_run_tc;
    logic        w_drain_last;
    logic        w_we;

    // Start is only honoured while idle or parked on a finished result.
    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;

    gcd_run_ctrl_run_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_run_timer (
        .clk  (clk),
        .rst  (rst),
        .i_en (r_state == ST_RUN),
        .o_tc (w_run_tc)
    );

    // Same counter structure reused to time the drain window.
    gcd_run_ctrl_run_timer #(
        .LIMIT (DRAIN_CYCLES)
    ) u_drain_timer (
        .clk  (clk),
        .rst  (rst),
        .i_en (r_state == ST_DRAIN),
        .o_tc (w_drain_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_LOAD_A;
            ST_DONE:   if (start) w_next = ST_LOAD_A;
            ST_LOAD_A: w_next = ST_LOAD_B;
            ST_LOAD_B: w_next = ST_RUN;
            ST_RUN:    if (cpu_halt || w_run_tc) w_next = ST_DRAIN;
            ST_DRAIN:  if (w_drain_last) w_next = ST_READ;
            ST_READ:   w_next = ST_DONE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Port mux: CPU owns the memory while running or draining, the
    // controller owns it otherwise.
    always_comb begin
        w_we      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rst   = 1'b1;
        cpu_run   = 1'b0;
        case (r_state)
            ST_LOAD_A: begin
                w_we      = 1'b1;
                mem_addr  = ADDR_A;
                mem_wdata = zext_byte(r_sw_a);
            end
            ST_LOAD_B: begin
                w_we      = 1'b1;
                mem_addr  = ADDR_B;
                mem_wdata = zext_byte(r_sw_b);
            end
            ST_RUN: begin
                cpu_rst   = 1'b0;
                cpu_run   = 1'b1;
                w_we      = cpu_mem_we;
                mem_addr  = cpu_mem_addr;
                mem_wdata = cpu_mem_wdata;
            end
            ST_DRAIN: begin
                cpu_rst   = 1'b0;
                w_we      = cpu_mem_we;
                mem_addr  = cpu_mem_addr;
                mem_wdata = cpu_mem_wdata;
            end
            ST_READ: begin
                mem_addr  = ADDR_R;
            end
            default: begin
            end
        endcase
    end

    // Belt-and-braces: no store may reach memory while reset is asserted.
    assign mem_we = w_we & ~rst;

    // Operand capture needs no reset: it is always loaded before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sw_a <= sw_a;
            r_sw_b <= sw_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end
            // Halt has priority over the timeout on the same cycle.
            if ((r_state == ST_RUN) && !cpu_halt && w_run_tc) begin
                r_timeout <= 1'b1;
            end
            if (r_state == ST_READ) begin
                r_result <= mem_rdata;
                r_done   <= 1'b1;
            end
        end
    end

    assign result  = r_result;
    assign done    = r_done;
    assign timeout = r_timeout;

endmodule
